// File: rtl/poly_sub_ctrl.sv
// Streams two coefficient RAMs through one mod_sub and writes r = a-b (or b-a) mod 3329.
// Three-stage pipeline: read issue, RAM data + mod_sub, registered write.

module mod_sub (
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic [11:0] r
);
    logic [12:0] d;

    assign d = {1'b0, x} - {1'b0, y};
    // On borrow the low 12 bits plus q wrap mod 4096 onto the correct residue
    assign r = d[12] ? (d[11:0] + 12'd3329) : d[11:0];
endmodule

module poly_sub_ctrl #(
    parameter int N      = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              swap,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_a_data,
    input  logic [11:0]       rd_b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int STAGES = 2;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    logic [1:0]                      state;
    logic [ADDR_W-1:0]               idx;
    logic                            drain_cnt;
    logic                            swap_q;
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:1][ADDR_W-1:0]     addr_pipe;
    logic [11:0]                     sub_x, sub_y, sub_r;
    logic                            accept;

    assign accept  = (state == S_IDLE) && start;
    assign busy    = (state == S_RUN) || (state == S_DRAIN);
    assign done    = (state == S_DONE);
    assign rd_en   = vld_pipe[0];
    assign rd_addr = idx;
    assign wr_en   = vld_pipe[STAGES];
    assign wr_addr = addr_pipe[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            drain_cnt <= 1'b0;
            swap_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    swap_q <= swap;
                    idx    <= '0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) state <= S_DONE;
                    drain_cnt <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign sub_x = swap_q ? rd_b_data : rd_a_data;
    assign sub_y = swap_q ? rd_a_data : rd_b_data;

    mod_sub u_sub (.x(sub_x), .y(sub_y), .r(sub_r));

    // Read strobe is registered so it is already high in the first RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            wr_data   <= '0;
        end else begin
            vld_pipe[0]  <= accept || ((state == S_RUN) && (idx != LAST));
            vld_pipe[1]  <= vld_pipe[0];
            vld_pipe[2]  <= vld_pipe[1];
            addr_pipe[1] <= idx;
            addr_pipe[2] <= addr_pipe[1];
            if (vld_pipe[1]) wr_data <= sub_r;
        end
    end
endmodule

// File: tb/tb_poly_sub_ctrl.sv
// Self-checking bench for poly_sub_ctrl: cycle-exact schedule checks, vector table, random runs.

module tb_poly_sub_ctrl;
    localparam int N  = 256;
    localparam int AW = 8;
    localparam int Q  = 3329;

    logic          clk = 1'b0;
    logic          rst, start, swap;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [11:0]   rd_a_data, rd_b_data, wr_data;

    logic [11:0] mem_a [N];
    logic [11:0] mem_b [N];
    logic [11:0] r_mem [N];
    int          exp_r [N];

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int idx;
        int a;
        int b;
        int r_noswap;
        int r_swap;
    } vec_t;

    poly_sub_ctrl #(.N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .swap(swap),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a_data <= mem_a[rd_addr];
            rd_b_data <= mem_b[rd_addr];
        end
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    function automatic int ref_sub(input int x, input int y);
        return ((x - y) % Q + Q) % Q;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            if (mismatched <= 40)
                $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " rd_en"}, int'(rd_en), 0);
        chk({tag, " rd_addr"}, int'(rd_addr), 0);
        chk({tag, " wr_en"}, int'(wr_en), 0);
        chk({tag, " wr_addr"}, int'(wr_addr), 0);
        chk({tag, " wr_data"}, int'(wr_data), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle N+4.
    task automatic run_op(input logic sw, input bit tog, input bit pulse,
                          input int rst_at, input string tag);
        int  nwr   = 0;
        int  ndone = 0;
        bit  dead  = 0;
        for (int i = 0; i < N; i++)
            exp_r[i] = sw ? ref_sub(int'(mem_b[i]), int'(mem_a[i]))
                          : ref_sub(int'(mem_a[i]), int'(mem_b[i]));
        start = 1'b1;
        swap  = sw;
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (tog) swap = 1'($urandom_range(0, 1));
            if (dead) begin
                chk({tag, " post-rst busy"}, int'(busy), 0);
                chk({tag, " post-rst wr_en"}, int'(wr_en), 0);
                chk({tag, " post-rst done"}, int'(done), 0);
            end else begin
                chk({tag, " rd_en"}, int'(rd_en), int'(k <= N));
                if (k <= N) chk({tag, " rd_addr"}, int'(rd_addr), k - 1);
                chk({tag, " busy"}, int'(busy), int'(k <= N + 2));
                chk({tag, " done"}, int'(done), int'(k == N + 3));
                chk({tag, " wr_en"}, int'(wr_en), int'(k >= 3 && k <= N + 2));
                if (k >= 3 && k <= N + 2) begin
                    chk({tag, " wr_addr"}, int'(wr_addr), k - 3);
                    chk({tag, " wr_data"}, int'(wr_data), exp_r[k - 3]);
                end
            end
            nwr   += int'(wr_en);
            ndone += int'(done);
            if (pulse && (k == 10 || k == N + 3)) start = 1'b1;
            if (rst_at == k) begin
                #1 rst = 1'b1;
                #1 chk_all_zero({tag, " async-rst"});
                dead = 1;
            end
        end
        chk({tag, " write count"}, nwr, (rst_at > 0) ? rst_at - 2 : N);
        chk({tag, " done pulses"}, ndone, (rst_at > 0) ? 0 : 1);
        if (rst_at == 0)
            for (int i = 0; i < N; i++)
                chk({tag, " R mem"}, int'(r_mem[i]), exp_r[i]);
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{0, 0,    3328, 1,    3328};
        vecs[1] = '{1, 3328, 0,    3328, 1};
        vecs[2] = '{2, 1234, 1234, 0,    0};
        vecs[3] = '{3, 5,    10,   3324, 5};

        rst   = 1'b1;
        start = 1'b0;
        swap  = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // Basic ramp with ignored start pulses, chained straight into a second run
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 12'(i);
            mem_b[i] = 12'(2 * i);
        end
        run_op(1'b0, 1'b0, 1'b1, 0, "basic");
        chk("basic R0", int'(r_mem[0]), 0);
        chk("basic R1", int'(r_mem[1]), 3328);
        chk("basic R5", int'(r_mem[5]), 3324);
        for (int i = 0; i < N; i++) r_mem[i] = 12'hfff;
        run_op(1'b0, 1'b0, 1'b0, 0, "chained");

        // Boundary table, plain and swapped (swap input toggling mid-run)
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 12'($urandom_range(0, Q - 1));
            mem_b[i] = 12'($urandom_range(0, Q - 1));
        end
        foreach (vecs[j]) begin
            mem_a[vecs[j].idx] = 12'(vecs[j].a);
            mem_b[vecs[j].idx] = 12'(vecs[j].b);
        end
        run_op(1'b0, 1'b0, 1'b0, 0, "table");
        foreach (vecs[j]) chk("table noswap", int'(r_mem[vecs[j].idx]), vecs[j].r_noswap);
        run_op(1'b1, 1'b1, 1'b0, 0, "swap");
        foreach (vecs[j]) chk("table swap", int'(r_mem[vecs[j].idx]), vecs[j].r_swap);

        // Reset mid-operation, then a clean run
        run_op(1'b0, 1'b0, 1'b0, 100, "rst-mid");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after-rst");
        run_op(1'b1, 1'b0, 1'b0, 0, "post-rst");

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] = 12'($urandom_range(0, Q - 1));
                mem_b[i] = 12'($urandom_range(0, Q - 1));
            end
            run_op(1'($urandom_range(0, 1)), 1'b1, 1'b0, 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
